memphy_seq: RTL and testbench
=============================

Name: memphy_seq

Overview:
- Per-burst sequencer for the DDR PHY, generalised to LANES byte lanes and a configurable burst length.
- Sits between the memory controller and the PHY primitive wrapper, entirely in the PHY's `clk` domain.
- Write side: schedules write latency, DQS preamble, data beats and postamble, and generates the per-lane dqout/dqt/dqspre.
- Read side: aligns captured dqin to a run-time read latency and emits valid-tagged read beats.

Parameters:
- LANES, 1: number of 8-bit byte lanes.
- BURST, 4: DDR beats per burst. Must be even and >= 2. The burst takes BURST/2 clk cycles.
- RL_MAX, 15: maximum supported read latency in clk cycles. Sets the read shift-register depth.
- WL, 1: write latency in clk cycles from wr_start to the preamble cycle. May be 0.

Ports:
- clk  in  1  PHY system clock.
- rstn  in  1  asynchronous active-low reset.
- cfg_rl  in  4  read latency in clk cycles, range 1..RL_MAX. Quasi-static: change only while busy=0.
- wr_start  in  1  pulse, same cycle the controller issues WRITE.
- wr_valid  in  1  write data valid.
- wr_ready  out  1  write data accepted when wr_valid&&wr_ready.
- wr_data  in  16*LANES  one clk cycle of data. Per lane i, bits [16i+7:16i] are the first (rising) edge and [16i+15:16i+8] the second edge.
- rd_req  in  1  pulse, same cycle the controller issues READ.
- rd_valid  out  1  rd_data carries one clk cycle of read data.
- rd_data  out  16*LANES  same byte layout as wr_data.
- phy_dqout  out  16*LANES  to PHY ddrdqout.
- phy_dqt  out  LANES  to PHY ddrdqt. 1 = tristate.
- phy_dqspre  out  LANES  to PHY ddrdqspre.
- phy_dqin  in  16*LANES  from PHY ddrdqin.
- busy  out  1  write FSM not in IDLE.
- cmd_err  out  1  sticky error flag, cleared only by reset.

Behaviour:
- Reset (async, rstn=0): phy_dqt=all 1, phy_dqspre=0, phy_dqout=0, wr_ready=0, rd_valid=0, rd_data=0, busy=0, cmd_err=0, FSM=IDLE, read pipeline cleared.
- Reset mid-burst: tristates DQ and DQS immediately. No partial beat is emitted after rstn rises.
- All outputs are registered. All per-lane outputs are identical across lanes; they are replicated so LANES can be split later.
- Write FSM states and transitions:
  - IDLE: on wr_start go to WLAT, loading a counter with WL. If WL=0, go directly to WPRE.
  - WLAT: decrement the counter; go to WPRE when it reaches 1.
  - WPRE (1 cycle): phy_dqspre=1, phy_dqt=1, wr_ready=1. Go to WDATA.
  - WDATA (BURST/2 cycles): phy_dqt=0; phy_dqout is the word accepted in the previous cycle. wr_ready=1 in every WDATA cycle except the last. Go to WPOST.
  - WPOST (1 cycle): phy_dqt=1, phy_dqspre=1, then return to IDLE.
  - busy=1 in every state except IDLE.
- Write underrun (wr_ready=1 with wr_valid=0): the next beat drives 0, cmd_err is set, and the burst continues with the same length.
- wr_start while busy=1: ignored, cmd_err set.
- Read pipeline:
  - rd_req enters an RL_MAX-deep shift register.
  - When the tap at index cfg_rl is 1, a beat counter loads BURST/2.
  - While the counter is nonzero: rd_data <= phy_dqin, rd_valid=1, counter decrements.
  - Total: the first rd_valid appears exactly cfg_rl+1 cycles after rd_req.
- Back-to-back reads: a tap hit while the counter is nonzero reloads it, giving seamless bursts. Spacing closer than BURST/2 truncates the earlier burst and sets cmd_err.
- Read/write collision: if a read beat is captured in a cycle with any phy_dqt=0, rd_valid is still asserted and cmd_err is set.
- cfg_rl=0 or cfg_rl>RL_MAX: treated as RL_MAX.

Decomposition:
- Shared package memphy_pkg holds:
  - write FSM state encoding (IDLE, WLAT, WPRE, WDATA, WPOST);
  - LANE_W=16 constant;
  - function beats2cyc(BURST).
- One sub-module: memphy_rdalign, containing the rd_req shift register, tap mux, beat counter and the rd_data/rd_valid registers. The top level holds the write FSM and the error logic.

Test Plan:
- Reset with rstn=0 mid-WDATA -> same cycle phy_dqt=all 1, phy_dqspre=0, busy=0; after release no rd_valid or wr_ready.
- WL=1, BURST=4, wr_start at cycle 0, wr_valid held 1, data 0x1111, 0x2222 -> cycle 1 phy_dqspre=1, phy_dqt=1; cycles 2-3 phy_dqt=0, phy_dqout=0x1111 then 0x2222; cycle 4 postamble; cycle 5 busy=0, cmd_err=0.
- Same as above but wr_valid=0 on the second accept cycle -> cycle 3 phy_dqout=0x0000, cmd_err=1 and stays 1 until reset.
- cfg_rl=5, rd_req at cycle 0, phy_dqin=cycle number -> rd_valid in cycles 6-7, rd_data=5, 6.
- cfg_rl=3, rd_req at cycles 0 and 2 -> rd_valid continuous in cycles 4-7, cmd_err=0. rd_req at cycles 0 and 1 -> rd_valid in cycles 4-6, cmd_err=1.
- wr_start at cycle 0 and again at cycle 2 (WL=1) -> single burst only, cmd_err=1. Also with LANES=2: every per-lane output equals the other lane's.

Source files
------------

// File: rtl/memphy_seq_pkg.sv
// Shared types and constants for the DDR PHY burst sequencer.
package memphy_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_WLAT, ST_WPRE, ST_WDATA, ST_WPOST} wr_state_t;

  localparam int LANE_W = 16;

  function automatic int beats2cyc(input int burst);
    return burst / 2;
  endfunction
endpackage

// File: rtl/memphy_seq_if.sv
// Controller/PHY-side signal bundle for memphy_seq; slave = sequencer, master = driver of it.
interface memphy_seq_if #(parameter int LANES = 1);
  import memphy_pkg::*;
  logic [3:0]              cfg_rl;
  logic                    wr_start;
  logic                    wr_valid;
  logic                    wr_ready;
  logic [LANE_W*LANES-1:0] wr_data;
  logic                    rd_req;
  logic                    rd_valid;
  logic [LANE_W*LANES-1:0] rd_data;
  logic [LANE_W*LANES-1:0] phy_dqout;
  logic [LANES-1:0]        phy_dqt;
  logic [LANES-1:0]        phy_dqspre;
  logic [LANE_W*LANES-1:0] phy_dqin;
  logic                    busy;
  logic                    cmd_err;

  modport slave (
    input  cfg_rl, wr_start, wr_valid, wr_data, rd_req, phy_dqin,
    output wr_ready, rd_valid, rd_data, phy_dqout, phy_dqt, phy_dqspre, busy, cmd_err
  );
  modport master (
    output cfg_rl, wr_start, wr_valid, wr_data, rd_req, phy_dqin,
    input  wr_ready, rd_valid, rd_data, phy_dqout, phy_dqt, phy_dqspre, busy, cmd_err
  );
endinterface

// File: rtl/memphy_seq_rdalign.sv
// Read-latency alignment: delays rd_req by cfg_rl cycles, then captures BURST/2 words of dqin.
module memphy_rdalign
  import memphy_pkg::*;
#(
  parameter int LANES  = 1,
  parameter int BURST  = 4,
  parameter int RL_MAX = 15
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    i_rd_req,
  input  logic [3:0]              i_cfg_rl,
  input  logic [LANE_W*LANES-1:0] i_dqin,
  output logic                    o_rd_valid,
  output logic [LANE_W*LANES-1:0] o_rd_data,
  output logic                    o_cap,
  output logic                    o_trunc
);
  localparam logic [7:0] B2 = 8'(beats2cyc(BURST));

  logic [RL_MAX:1]         r_sr;
  logic [7:0]              r_cnt;
  logic                    r_rd_valid;
  logic [LANE_W*LANES-1:0] r_rd_data;
  logic [3:0]              w_rl;
  logic                    w_hit;

  // r_sr[j] holds the request issued j cycles ago; out-of-range latencies fall back to RL_MAX
  always_comb begin
    w_rl = i_cfg_rl;
    if (i_cfg_rl == 4'd0 || 32'(i_cfg_rl) > RL_MAX) w_rl = 4'(RL_MAX);
    w_hit = 1'b0;
    for (int j = 1; j <= RL_MAX; j++)
      if (32'(w_rl) == j) w_hit = r_sr[j];
  end

  // A hit captures its first beat immediately, so the counter holds the beats still to come
  assign o_cap   = w_hit || (r_cnt != 8'd0);
  assign o_trunc = w_hit && (r_cnt != 8'd0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sr       <= '0;
      r_cnt      <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_sr[1] <= i_rd_req;
      for (int j = 2; j <= RL_MAX; j++) r_sr[j] <= r_sr[j-1];
      r_rd_valid <= o_cap;
      if (o_cap) r_rd_data <= i_dqin;
      if (w_hit)                r_cnt <= B2 - 8'd1;
      else if (r_cnt != 8'd0)   r_cnt <= r_cnt - 8'd1;
    end
  end

  assign o_rd_valid = r_rd_valid;
  assign o_rd_data  = r_rd_data;
endmodule

// File: rtl/memphy_seq.sv
// Per-burst DDR PHY sequencer: write FSM (latency, preamble, data, postamble) plus read alignment.
// state  | meaning
// IDLE   | no write in flight, DQ/DQS tristated
// WLAT   | counting down write latency
// WPRE   | DQS preamble, first data word accepted
// WDATA  | DQ driven with previously accepted word
// WPOST  | DQS postamble
module memphy_seq
  import memphy_pkg::*;
#(
  parameter int LANES  = 1,
  parameter int BURST  = 4,
  parameter int RL_MAX = 15,
  parameter int WL     = 1
) (
  input  logic         clk,
  input  logic         rstn,
  memphy_seq_if.slave  bus
);
  localparam logic [7:0] B2  = 8'(beats2cyc(BURST));
  localparam logic [7:0] WL8 = 8'(WL);

  wr_state_t               r_state, w_nxt;
  logic [7:0]              r_cnt, w_cnt_nxt;
  logic                    r_wr_ready, r_busy, r_err;
  logic [LANES-1:0]        r_dqt, r_dqspre;
  logic [LANE_W*LANES-1:0] r_dqout;
  logic                    w_accept, w_cap, w_trunc, w_rd_valid;
  logic [LANE_W*LANES-1:0] w_rd_data;

  assign w_accept = bus.wr_valid && r_wr_ready;

  always_comb begin
    w_nxt     = r_state;
    w_cnt_nxt = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (bus.wr_start) begin
          if (WL8 <= 8'd1) w_nxt = ST_WPRE;
          else begin
            w_nxt     = ST_WLAT;
            w_cnt_nxt = WL8 - 8'd1;
          end
        end
      end
      ST_WLAT: begin
        w_cnt_nxt = r_cnt - 8'd1;
        if (r_cnt <= 8'd1) w_nxt = ST_WPRE;
      end
      ST_WPRE: begin
        w_nxt     = ST_WDATA;
        w_cnt_nxt = B2;
      end
      ST_WDATA: begin
        w_cnt_nxt = r_cnt - 8'd1;
        if (r_cnt <= 8'd1) w_nxt = ST_WPOST;
      end
      ST_WPOST: w_nxt = ST_IDLE;
      default:  w_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_wr_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_dqt      <= '1;
      r_dqspre   <= '0;
      r_dqout    <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_nxt;
      r_cnt      <= w_cnt_nxt;
      r_busy     <= (w_nxt != ST_IDLE);
      r_wr_ready <= (w_nxt == ST_WPRE) || ((w_nxt == ST_WDATA) && (w_cnt_nxt > 8'd1));
      r_dqt      <= {LANES{w_nxt != ST_WDATA}};
      r_dqspre   <= {LANES{(w_nxt == ST_WPRE) || (w_nxt == ST_WPOST)}};
      r_dqout    <= ((w_nxt == ST_WDATA) && w_accept) ? bus.wr_data : '0;
      r_err      <= r_err
                  | (bus.wr_start && (r_state != ST_IDLE))
                  | (r_wr_ready && !bus.wr_valid)
                  | w_trunc
                  | (w_cap && !(&r_dqt));
    end
  end

  memphy_rdalign #(.LANES(LANES), .BURST(BURST), .RL_MAX(RL_MAX)) u_rdalign (
    .clk       (clk),
    .rstn      (rstn),
    .i_rd_req  (bus.rd_req),
    .i_cfg_rl  (bus.cfg_rl),
    .i_dqin    (bus.phy_dqin),
    .o_rd_valid(w_rd_valid),
    .o_rd_data (w_rd_data),
    .o_cap     (w_cap),
    .o_trunc   (w_trunc)
  );

  assign bus.wr_ready   = r_wr_ready;
  assign bus.busy       = r_busy;
  assign bus.phy_dqt    = r_dqt;
  assign bus.phy_dqspre = r_dqspre;
  assign bus.phy_dqout  = r_dqout;
  assign bus.cmd_err    = r_err;
  assign bus.rd_valid   = w_rd_valid;
  assign bus.rd_data    = w_rd_data;
endmodule

// File: tb/tb_memphy_seq.sv
// Directed bench for memphy_seq: per-test expectation tables built from burst/latency rules.
module tb_memphy_seq;
  import memphy_pkg::*;
  localparam int LANES = 2, BURST = 4, RL_MAX = 15, WL = 1;
  localparam int B2 = BURST / 2, MAXC = 40, WLAT = (WL < 1) ? 1 : WL;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  memphy_seq_if #(.LANES(LANES)) bus();
  memphy_seq #(.LANES(LANES), .BURST(BURST), .RL_MAX(RL_MAX), .WL(WL)) dut (
    .clk(clk), .rstn(rstn), .bus(bus)
  );

  int n_chk, n_pass, cur;
  bit chk_en;
  int cfg;

  bit          st_ws[MAXC], st_wv[MAXC], st_rr[MAXC];
  logic [15:0] st_wd[MAXC];
  bit          e_busy[MAXC], e_rdy[MAXC], e_dqt[MAXC], e_spre[MAXC], e_val[MAXC], e_err[MAXC];
  logic [15:0] e_dqout[MAXC], e_rdata[MAXC];
  bit          a_busy[MAXC], a_spre[MAXC], a_val[MAXC], a_err[MAXC], a_rdy[MAXC];
  logic [15:0] a_dqout[MAXC], a_rdata[MAXC];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cur, act, exp);
  endtask

  function automatic void clear_stim();
    for (int c = 0; c < MAXC; c++) begin
      st_ws[c] = 0; st_wv[c] = 0; st_rr[c] = 0; st_wd[c] = '0;
    end
  endfunction

  // Expected outputs derived from the burst timeline and read-latency rules
  function automatic void build_model();
    int start, idle_at, err_from, rem, rl, p;
    bit hit;
    start = -1; idle_at = 0; err_from = MAXC + 1; rem = 0;
    for (int c = 0; c < MAXC; c++) begin
      e_busy[c] = 0; e_rdy[c] = 0; e_dqt[c] = 1; e_spre[c] = 0;
      e_val[c] = 0; e_dqout[c] = '0; e_rdata[c] = '0;
    end
    for (int s = 0; s < MAXC; s++) if (st_ws[s]) begin
      if (s > start && s < idle_at) begin
        if (s + 1 < err_from) err_from = s + 1;
      end else begin
        start = s;
        p = s + WLAT;
        for (int c = s + 1; c <= p + B2 + 1 && c < MAXC; c++) e_busy[c] = 1;
        if (p < MAXC) e_spre[p] = 1;
        if (p + B2 + 1 < MAXC) e_spre[p + B2 + 1] = 1;
        for (int c = p + 1; c <= p + B2 && c < MAXC; c++) e_dqt[c] = 0;
        for (int a = p; a <= p + B2 - 1 && a + 1 < MAXC; a++) begin
          e_rdy[a] = 1;
          e_dqout[a + 1] = st_wv[a] ? st_wd[a] : 16'h0;
          if (!st_wv[a] && a + 1 < err_from) err_from = a + 1;
        end
        idle_at = p + B2 + 2;
      end
    end
    rl = (cfg == 0 || cfg > RL_MAX) ? RL_MAX : cfg;
    for (int t = 0; t < MAXC - 1; t++) begin
      hit = (t >= rl) && st_rr[t - rl];
      if (hit) begin
        if (rem > 0 && t + 1 < err_from) err_from = t + 1;
        rem = B2;
      end
      if (rem > 0) begin
        e_val[t + 1] = 1;
        e_rdata[t + 1] = 16'(t);
        if (!e_dqt[t] && t + 1 < err_from) err_from = t + 1;
        rem--;
      end
    end
    for (int c = 0; c < MAXC; c++) e_err[c] = (c >= err_from);
  endfunction

  always @(negedge clk) if (chk_en) begin
    a_busy[cur] = bus.busy; a_spre[cur] = bus.phy_dqspre[0]; a_val[cur] = bus.rd_valid;
    a_err[cur] = bus.cmd_err; a_rdy[cur] = bus.wr_ready;
    a_dqout[cur] = bus.phy_dqout[15:0]; a_rdata[cur] = bus.rd_data[15:0];
    chk("busy", 64'(bus.busy), 64'(e_busy[cur]));
    chk("wr_ready", 64'(bus.wr_ready), 64'(e_rdy[cur]));
    chk("rd_valid", 64'(bus.rd_valid), 64'(e_val[cur]));
    chk("cmd_err", 64'(bus.cmd_err), 64'(e_err[cur]));
    for (int l = 0; l < LANES; l++) begin
      chk("dqt", 64'(bus.phy_dqt[l]), 64'(e_dqt[cur]));
      chk("dqspre", 64'(bus.phy_dqspre[l]), 64'(e_spre[cur]));
      chk("dqout", 64'(bus.phy_dqout[16*l +: 16]), 64'(e_dqout[cur]));
      if (e_val[cur]) chk("rd_data", 64'(bus.rd_data[16*l +: 16]), 64'(e_rdata[cur]));
    end
  end

  task automatic idle();
    bus.wr_start = 0; bus.wr_valid = 0; bus.wr_data = '0; bus.rd_req = 0; bus.phy_dqin = '0;
  endtask

  task automatic do_reset();
    idle();
    bus.cfg_rl = 4'(cfg);
    rstn = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1;
  endtask

  task automatic run(input int n, input int rst_at);
    build_model();
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      cur = k; chk_en = 1;
      bus.wr_start = st_ws[k]; bus.wr_valid = st_wv[k]; bus.wr_data = {LANES{st_wd[k]}};
      bus.rd_req = st_rr[k]; bus.phy_dqin = {LANES{16'(k)}};
      if (k == rst_at) begin
        @(negedge clk); #1;
        chk_en = 0; rstn = 0; #1;
        chk("rst_dqt", 64'(bus.phy_dqt), 64'({LANES{1'b1}}));
        chk("rst_dqspre", 64'(bus.phy_dqspre), 64'(0));
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_dqout", 64'(bus.phy_dqout), 64'(0));
        chk("rst_wr_ready", 64'(bus.wr_ready), 64'(0));
        idle();
        return;
      end
    end
    @(negedge clk); #1;
    chk_en = 0;
    idle();
  endtask

  int n_spre;

  initial begin
    n_chk = 0; n_pass = 0; cur = 0; chk_en = 0; cfg = 5;
    idle();
    bus.cfg_rl = 4'd5;

    // Reset in the middle of the data phase, then quiet cycles afterwards
    clear_stim(); st_ws[0] = 1; for (int c = 0; c < MAXC; c++) st_wv[c] = 1;
    st_wd[1] = 16'hA5A5; st_wd[2] = 16'h5A5A;
    do_reset(); run(8, 2);
    clear_stim(); do_reset(); run(6, -1);

    // Plain write burst
    clear_stim(); st_ws[0] = 1; for (int c = 0; c < MAXC; c++) st_wv[c] = 1;
    st_wd[1] = 16'h1111; st_wd[2] = 16'h2222;
    do_reset(); run(8, -1);
    chk("model_dq_c2", 64'(e_dqout[2]), 64'h1111);
    chk("model_spre_c1", 64'(e_spre[1]), 64'd1);
    chk("wr_spre_c1", 64'(a_spre[1]), 64'd1);
    chk("wr_dq_c2", 64'(a_dqout[2]), 64'h1111);
    chk("wr_dq_c3", 64'(a_dqout[3]), 64'h2222);
    chk("wr_post_c4", 64'(a_spre[4]), 64'd1);
    chk("wr_busy_c5", 64'(a_busy[5]), 64'd0);
    chk("wr_err_c5", 64'(a_err[5]), 64'd0);

    // Underrun on the second accept cycle
    clear_stim(); st_ws[0] = 1; for (int c = 0; c < MAXC; c++) st_wv[c] = 1;
    st_wv[2] = 0; st_wd[1] = 16'h1111; st_wd[2] = 16'h2222;
    do_reset(); run(10, -1);
    chk("ur_dq_c3", 64'(a_dqout[3]), 64'h0);
    chk("ur_err_c3", 64'(a_err[3]), 64'd1);
    chk("ur_err_c9", 64'(a_err[9]), 64'd1);

    // Single read, latency 5
    clear_stim(); cfg = 5; st_rr[0] = 1;
    do_reset(); run(10, -1);
    chk("model_rdata_c6", 64'(e_rdata[6]), 64'd5);
    chk("rd_val_c5", 64'(a_val[5]), 64'd0);
    chk("rd_data_c6", 64'(a_rdata[6]), 64'd5);
    chk("rd_data_c7", 64'(a_rdata[7]), 64'd6);
    chk("rd_val_c8", 64'(a_val[8]), 64'd0);

    // Seamless back-to-back reads
    clear_stim(); cfg = 3; st_rr[0] = 1; st_rr[2] = 1;
    do_reset(); run(10, -1);
    chk("b2b_val", 64'({a_val[4], a_val[5], a_val[6], a_val[7]}), 64'hF);
    chk("b2b_err", 64'(a_err[9]), 64'd0);

    // Too-close reads truncate the first burst
    clear_stim(); cfg = 3; st_rr[0] = 1; st_rr[1] = 1;
    do_reset(); run(10, -1);
    chk("trunc_val", 64'({a_val[4], a_val[5], a_val[6], a_val[7]}), 64'hE);
    chk("trunc_err", 64'(a_err[9]), 64'd1);

    // wr_start while busy is ignored
    clear_stim(); cfg = 5; st_ws[0] = 1; st_ws[2] = 1;
    for (int c = 0; c < MAXC; c++) begin st_wv[c] = 1; st_wd[c] = 16'(16'h0100 + c); end
    do_reset(); run(12, -1);
    n_spre = 0;
    for (int c = 0; c < 12; c++) n_spre += int'(a_spre[c]);
    chk("busy_start_spre_cnt", 64'(n_spre), 64'd2);
    chk("busy_start_err", 64'(a_err[11]), 64'd1);

    // cfg_rl = 0 falls back to RL_MAX
    clear_stim(); cfg = 0; st_rr[0] = 1;
    do_reset(); run(20, -1);
    chk("rl0_val_c16", 64'(a_val[16]), 64'd1);
    chk("rl0_data_c16", 64'(a_rdata[16]), 64'd15);

    // Read beat captured while DQ is driven
    clear_stim(); cfg = 1; st_ws[0] = 1; st_rr[1] = 1;
    for (int c = 0; c < MAXC; c++) begin st_wv[c] = 1; st_wd[c] = 16'hBEEF; end
    do_reset(); run(8, -1);
    chk("coll_val_c3", 64'(a_val[3]), 64'd1);
    chk("coll_err_c3", 64'(a_err[3]), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
